gp_axis_host_driver: RTL and testbench
======================================

// Module: gp_axis_host_driver
// PURPOSE
//  Host-side counterpart of the GP AXI-Stream accelerator interface. On start, reads IN_DATA_NUM
//  words from a source memory and sends them as one AXIS packet on m_* (TLAST on the final word).
//  It then accepts the OUT_DATA_NUM-word result packet on s_* and writes it to a destination memory.
//  Used as DMA-lite in the SoC wrapper and as the driver in system benches.
// PARAMETERS
//  DATA_WIDTH     32  stream/memory word width
//  IN_DATA_NUM    8   words sent per request packet (>=1)
//  OUT_DATA_NUM   4   words expected per result packet (>=1)
//  IN_ADR_WIDTH   8   source memory address width; must satisfy 2**IN_ADR_WIDTH >= IN_DATA_NUM
//  OUT_ADR_WIDTH  8   destination memory address width; must satisfy 2**OUT_ADR_WIDTH >= OUT_DATA_NUM
// PORTS
//  clk       in   1              single clock, all logic posedge
//  rst_n     in   1              reset, synchronous, active-low
//  start     in   1              1-cycle request; sampled only in IDLE
//  busy      out  1              high in every state except IDLE
//  done      out  1              1-cycle pulse when the transaction completes
//  err       out  1              TLAST mismatch on the result packet; held until next accepted start
//  rcv_cnt   out  OUT_ADR_WIDTH+1  number of result words written; valid from done until next start
//  src_adr   out  IN_ADR_WIDTH   source memory read address
//  src_rd    out  1              read strobe; src_data is valid exactly 1 cycle later
//  src_data  in   DATA_WIDTH     source memory read data
//  dst_adr   out  OUT_ADR_WIDTH  destination memory write address
//  dst_data  out  DATA_WIDTH     destination write data (combinational from s_data)
//  dst_wr    out  1              destination write strobe
//  m_data    out  DATA_WIDTH     AXIS master data (registered)
//  m_valid   out  1              AXIS master valid
//  m_last    out  1              AXIS master last
//  m_ready   in   1              AXIS master ready
//  s_data    in   DATA_WIDTH     AXIS slave data
//  s_valid   in   1              AXIS slave valid
//  s_last    in   1              AXIS slave last
//  s_ready   out  1              AXIS slave ready
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state->IDLE, counters->0; busy, done, err, rcv_cnt, src_rd, dst_wr,
//   m_valid, m_last, s_ready, m_data all 0. Reset mid-transaction abandons the packet, with no done pulse.
//  FSM states: IDLE, RD, LOAD, SEND, RECV, FIN.
//   IDLE: start=1 -> RD; clear in_cnt, out_cnt, err, rcv_cnt. start in any other state is ignored.
//   RD:   src_rd=1, src_adr=in_cnt -> LOAD.
//   LOAD: m_data<=src_data registered -> SEND.
//   SEND: m_valid=1; m_last=(in_cnt==IN_DATA_NUM-1). m_data, m_last stay stable while m_ready=0.
//         On m_valid&m_ready: if last word -> RECV, else in_cnt++ -> RD.
//         Throughput is 1 word per 3 cycles; m_valid is never withdrawn before acceptance.
//   RECV: s_ready=1. On s_valid: dst_wr=1, dst_adr=out_cnt, dst_data=s_data, out_cnt++, rcv_cnt++.
//         Early last (s_last=1, out_cnt<OUT_DATA_NUM-1) -> err=1, go to FIN.
//         Word OUT_DATA_NUM-1 accepted -> FIN; err=1 if s_last=0 on that word.
//         No words are dropped and none are written past OUT_DATA_NUM-1.
//   FIN:  done=1 for one cycle -> IDLE.
//  s_ready is 0 outside RECV, so results arriving during SEND are back-pressured, not lost.
//  Latency: start -> first m_valid = 3 cycles; last s handshake -> done = 1 cycle.
//  Counters wrap only via clear in IDLE and never exceed their terminal counts.
//  Back-to-back operation: start asserted in the same cycle as done is ignored (state is FIN);
//   start asserted in the following cycle (IDLE) is accepted.
// TESTING
//  1 Defaults, src[i]=i+1, m_ready=1 -> m_data 1..8; m_last only with 8; first m_valid 3 cyc after start.
//  2 m_ready toggles 0/1 every cycle -> identical word order; m_data stable during stalls; no word lost.
//  3 Responder returns A0..A3 with s_last on A3 -> dst[0..3]=A0..A3, rcv_cnt=4, err=0, done 1 cycle.
//  4 s_last on 2nd result word -> dst writes 2, rcv_cnt=2, err=1, done; then IDLE.
//  5 4 result words without s_last -> 4 writes, err=1; 5th s_valid sees s_ready=0.
//  6 rst_n=0 for 1 cycle mid-SEND -> all outputs 0 next cycle, no done; new start runs cleanly.

Source files
------------

// File: rtl/gp_axis_host_driver.sv
// Host-side AXI-Stream driver: streams a source-memory block out as one packet,
// then collects the result packet into a destination memory.
module gp_axis_host_driver #(
  parameter int DATA_WIDTH    = 32,
  parameter int IN_DATA_NUM   = 8,
  parameter int OUT_DATA_NUM  = 4,
  parameter int IN_ADR_WIDTH  = 8,
  parameter int OUT_ADR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [OUT_ADR_WIDTH:0]   rcv_cnt,
  output logic [IN_ADR_WIDTH-1:0]  src_adr,
  output logic                     src_rd,
  input  logic [DATA_WIDTH-1:0]    src_data,
  output logic [OUT_ADR_WIDTH-1:0] dst_adr,
  output logic [DATA_WIDTH-1:0]    dst_data,
  output logic                     dst_wr,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] RECV = 3'd4;
  localparam logic [2:0] FIN  = 3'd5;

  localparam logic [IN_ADR_WIDTH-1:0]  IN_LAST  = IN_ADR_WIDTH'(IN_DATA_NUM - 1);
  localparam logic [OUT_ADR_WIDTH-1:0] OUT_LAST = OUT_ADR_WIDTH'(OUT_DATA_NUM - 1);

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic [IN_ADR_WIDTH-1:0]  in_cnt;
  logic [OUT_ADR_WIDTH-1:0] out_cnt;
  logic                     accept_start;
  logic                     m_fire;
  logic                     s_fire;
  logic                     in_last;
  logic                     out_last;

  assign accept_start = (state == IDLE) && start;
  assign m_fire       = (state == SEND) && m_ready;
  assign s_fire       = (state == RECV) && s_valid;
  assign in_last      = (in_cnt == IN_LAST);
  assign out_last     = (out_cnt == OUT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RD;
      RD:   state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: if (m_ready) state_nxt = in_last ? RECV : RD;
      RECV: if (s_valid && (s_last || out_last)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counters stop at their terminal index so they always fit the address width.
  always_ff @(posedge clk) begin
    if (!rst_n)                 in_cnt <= '0;
    else if (accept_start)      in_cnt <= '0;
    else if (m_fire && !in_last) in_cnt <= in_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                   out_cnt <= '0;
    else if (accept_start)        out_cnt <= '0;
    else if (s_fire && !out_last) out_cnt <= out_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)            rcv_cnt <= '0;
    else if (accept_start) rcv_cnt <= '0;
    else if (s_fire)       rcv_cnt <= rcv_cnt + 1'b1;
  end

  // Error when TLAST does not coincide with the final expected result word.
  always_ff @(posedge clk) begin
    if (!rst_n)                          err <= 1'b0;
    else if (accept_start)               err <= 1'b0;
    else if (s_fire && (s_last != out_last)) err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              m_data <= '0;
    else if (state == LOAD)  m_data <= src_data;
  end

  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  assign src_rd   = (state == RD);
  assign src_adr  = in_cnt;
  assign m_valid  = (state == SEND);
  assign m_last   = (state == SEND) && in_last;
  assign s_ready  = (state == RECV);
  assign dst_wr   = s_fire;
  assign dst_adr  = out_cnt;
  assign dst_data = s_data;

endmodule

// File: tb/tb_gp_axis_host_driver.sv
// Directed bench for gp_axis_host_driver: source memory model, toggling or
// steady m_ready, scripted result responder and a cycle monitor on both streams.
module tb_gp_axis_host_driver;

  localparam int DW   = 32;
  localparam int INN  = 8;
  localparam int OUTN = 4;
  localparam int IAW  = 8;
  localparam int OAW  = 8;

  typedef struct {
    bit          toggleReady;
    logic [31:0] respBase;
    int          lastAt;
    int          expRcv;
    bit          expErr;
    int          extraWords;
    bit          chainStart;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           busy, done, err;
  logic [OAW:0]   rcv_cnt;
  logic [IAW-1:0] src_adr;
  logic           src_rd;
  logic [DW-1:0]  src_data = '0;
  logic [OAW-1:0] dst_adr;
  logic [DW-1:0]  dst_data;
  logic           dst_wr;
  logic [DW-1:0]  m_data;
  logic           m_valid, m_last;
  logic           m_ready = 1'b1;
  logic [DW-1:0]  s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic           s_ready;

  int          passCount = 0;
  int          checkCount = 0;
  bit          toggleReady = 1'b0;
  logic [31:0] respBase = '0;
  int          acceptedCount = 0;
  int          writeCount = 0;
  int          doneCount = 0;
  int          sinceStart = 0;
  int          firstValid = -1;
  bit          seenValid = 1'b0;
  bit          prevStall = 1'b0;

  gp_axis_host_driver #(
    .DATA_WIDTH(DW), .IN_DATA_NUM(INN), .OUT_DATA_NUM(OUTN),
    .IN_ADR_WIDTH(IAW), .OUT_ADR_WIDTH(OAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err(err), .rcv_cnt(rcv_cnt), .src_adr(src_adr), .src_rd(src_rd),
    .src_data(src_data), .dst_adr(dst_adr), .dst_data(dst_data),
    .dst_wr(dst_wr), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  // Source memory holds word i+1 at address i, with one cycle of read latency.
  always @(posedge clk) begin
    if (src_rd) src_data <= 32'(src_adr) + 32'd1;
  end

  always @(negedge clk) begin
    m_ready = toggleReady ? ~m_ready : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: timed out, got no event, expected one", name);
  endtask

  // Mid-cycle monitor: values seen here describe the handshakes at the next posedge.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      acceptedCount = 0;
      writeCount    = 0;
      prevStall     = 1'b0;
      seenValid     = 1'b0;
    end else begin
      if (start && !busy) begin
        acceptedCount = 0;
        writeCount    = 0;
        doneCount     = 0;
        sinceStart    = 0;
        firstValid    = -1;
        seenValid     = 1'b0;
        prevStall     = 1'b0;
      end else begin
        sinceStart++;
      end
      if (prevStall) checkOutput("m_valid held during stall", {31'b0, m_valid}, 32'd1);
      if (m_valid) begin
        if (!seenValid) begin
          seenValid  = 1'b1;
          firstValid = sinceStart;
        end
        checkOutput("m_data order", m_data, 32'(acceptedCount + 1));
        checkOutput("m_last", {31'b0, m_last}, {31'b0, acceptedCount == INN - 1});
        if (m_ready) acceptedCount++;
      end
      prevStall = m_valid && !m_ready;
      if (dst_wr) begin
        checkOutput("dst_adr", {24'b0, dst_adr}, 32'(writeCount));
        checkOutput("dst_data", dst_data, respBase + 32'(writeCount));
        writeCount++;
      end
      if (done) doneCount++;
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"},    {31'b0, busy},    32'd0);
    checkOutput({tag, " done"},    {31'b0, done},    32'd0);
    checkOutput({tag, " err"},     {31'b0, err},     32'd0);
    checkOutput({tag, " rcv_cnt"}, {23'b0, rcv_cnt}, 32'd0);
    checkOutput({tag, " src_rd"},  {31'b0, src_rd},  32'd0);
    checkOutput({tag, " dst_wr"},  {31'b0, dst_wr},  32'd0);
    checkOutput({tag, " m_valid"}, {31'b0, m_valid}, 32'd0);
    checkOutput({tag, " m_last"},  {31'b0, m_last},  32'd0);
    checkOutput({tag, " s_ready"}, {31'b0, s_ready}, 32'd0);
    checkOutput({tag, " m_data"},  m_data,           32'd0);
  endtask

  // Runs one full transaction starting at a negedge; returns at the done cycle
  // when chainStart is set, otherwise one cycle after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    bit got;
    toggleReady = v.toggleReady;
    respBase    = v.respBase;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < v.expRcv; k++) begin
      s_valid = 1'b1;
      s_data  = v.respBase + 32'(k);
      s_last  = (k == v.lastAt);
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (s_ready) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!got) begin
        reportTimeout({tag, " result handshake"});
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput({tag, " done pulse"},    {31'b0, done},    32'd1);
    checkOutput({tag, " err"},           {31'b0, err},     {31'b0, v.expErr});
    checkOutput({tag, " rcv_cnt"},       {23'b0, rcv_cnt}, 32'(v.expRcv));
    checkOutput({tag, " dst writes"},    32'(writeCount),  32'(v.expRcv));
    checkOutput({tag, " words sent"},    32'(acceptedCount), 32'(INN));
    checkOutput({tag, " start latency"}, 32'(firstValid),  32'd3);
    if (v.chainStart) return;
    for (int x = 0; x < v.extraWords; x++) begin
      s_valid = 1'b1;
      s_data  = v.respBase + 32'(v.expRcv + x);
      for (int c = 0; c < 3; c++) begin
        checkOutput({tag, " extra word s_ready"}, {31'b0, s_ready}, 32'd0);
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    if (v.extraWords == 0) @(negedge clk);
    checkOutput({tag, " idle busy"},   {31'b0, busy},   32'd0);
    checkOutput({tag, " idle done"},   {31'b0, done},   32'd0);
    checkOutput({tag, " done count"},  32'(doneCount),  32'd1);
    checkOutput({tag, " final writes"}, 32'(writeCount), 32'(v.expRcv));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    vec_t chained;
    bit gotValid;
    vecs[0] = '{toggleReady: 1'b0, respBase: 32'hA0, lastAt: 3,  expRcv: 4, expErr: 1'b0, extraWords: 0, chainStart: 1'b0};
    vecs[1] = '{toggleReady: 1'b1, respBase: 32'hB0, lastAt: 3,  expRcv: 4, expErr: 1'b0, extraWords: 0, chainStart: 1'b0};
    vecs[2] = '{toggleReady: 1'b0, respBase: 32'hC0, lastAt: 1,  expRcv: 2, expErr: 1'b1, extraWords: 0, chainStart: 1'b0};
    vecs[3] = '{toggleReady: 1'b1, respBase: 32'hD0, lastAt: -1, expRcv: 4, expErr: 1'b1, extraWords: 1, chainStart: 1'b0};
    chained = '{toggleReady: 1'b0, respBase: 32'hE0, lastAt: 3,  expRcv: 4, expErr: 1'b0, extraWords: 0, chainStart: 1'b1};

    $display("[TB] reset phase");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] back-to-back start and reset during SEND");
    applyStimulus(chained, "chained");
    start = 1'b1;
    @(negedge clk);
    checkOutput("start during done ignored", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("start in idle accepted", {31'b0, busy}, 32'd1);
    start = 1'b0;
    checkOutput("err cleared by start", {31'b0, err}, 32'd0);
    checkOutput("rcv_cnt cleared by start", {23'b0, rcv_cnt}, 32'd0);
    gotValid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (m_valid) begin
        gotValid = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!gotValid) reportTimeout("m_valid before reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkAllZero("mid-send reset");
    repeat (3) @(negedge clk);
    checkOutput("no done after abandoned packet", 32'(doneCount), 32'd0);
    checkOutput("idle after abandoned packet", {31'b0, busy}, 32'd0);

    $display("[TB] clean run after reset");
    applyStimulus(vecs[0], "post-reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
